// File: rtl/run_detector_pkg.sv
// Shared types and constants for the run-length detector arbiter.
// The channel count field is sized for the largest legal run length (15).
package run_detector_pkg;

  localparam int RUN_LEN_MAX = 15;
  localparam int CNT_W       = $clog2(RUN_LEN_MAX + 1);
  localparam int STAT_W      = 8;

  typedef struct packed {
    logic             last;
    logic [CNT_W-1:0] cnt;
  } chan_state_t;

  localparam chan_state_t CHAN_STATE_RST = '{last: 1'b0, cnt: {CNT_W{1'b0}}};

  // Saturating increment, never wraps past lim.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] cnt,
                                                   input logic [CNT_W-1:0] lim);
    return (cnt >= lim) ? lim : (cnt + {{(CNT_W-1){1'b0}}, 1'b1});
  endfunction

endpackage

// File: rtl/run_detector_arbiter_if.sv
// Request/grant and detect-result bundle between serial bit sources and the
// shared run detector.
interface run_detector_arbiter_if #(
  parameter int N_CH = 4
);

  localparam int CH_W = $clog2(N_CH);

  logic [N_CH-1:0] req;
  logic [N_CH-1:0] w;
  logic [N_CH-1:0] clr;
  logic [N_CH-1:0] gnt;
  logic [N_CH-1:0] z;
  logic            match_valid;
  logic [CH_W-1:0] match_ch;

  modport master (
    output req, w, clr,
    input  gnt, z, match_valid, match_ch
  );

  modport slave (
    input  req, w, clr,
    output gnt, z, match_valid, match_ch
  );

endinterface

// File: rtl/run_detector_core.sv
// Combinational next-state function of one run-length detector channel;
// a single instance is time-shared across all channels by the arbiter.
module run_detector_core
  import run_detector_pkg::*;
#(
  parameter int RUN_LEN = 4
) (
  input  chan_state_t state_in,
  input  logic        w,
  output chan_state_t state_out,
  output logic        z_next,
  output logic        rise
);

  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(RUN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Run tracking: a fresh or broken run restarts at one, otherwise extend.
  always_comb begin
    state_out = state_in;
    if ((state_in.cnt == {CNT_W{1'b0}}) || (w != state_in.last)) begin
      state_out.last = w;
      state_out.cnt  = CNT_ONE;
    end else begin
      state_out.cnt  = cnt_sat_inc(state_in.cnt, CNT_LIM);
    end
    z_next = (state_out.cnt == CNT_LIM);
    rise   = (state_in.cnt == CNT_PRE) && z_next;
  end

endmodule

// File: rtl/run_detector_arbiter.sv
// Round-robin sharing of one run-length detector among N_CH bit channels.
// Define RUNDET_STATS_EN to add per-channel saturating match counters.
module run_detector_arbiter
  import run_detector_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int RUN_LEN = 4,
  localparam int CH_W   = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  reset,
  run_detector_arbiter_if.slave bus,
  input  logic [CH_W-1:0]       stat_sel,
  output logic [STAT_W-1:0]     stat_cnt
);

  logic [N_CH-1:0] elig_s;
  logic [N_CH-1:0] gnt_s;
  logic [CH_W-1:0] gnt_idx_s;
  logic [CH_W-1:0] cand_s;
  logic [CH_W-1:0] ptr_next_s;
  logic            gnt_any_s;
  logic            hit_s;

  logic [CH_W-1:0] ptr_r;
  chan_state_t     state_r [N_CH];
  logic [N_CH-1:0] z_r;
  logic            match_valid_r;
  logic [CH_W-1:0] match_ch_r;

  chan_state_t     core_in_s;
  chan_state_t     core_out_s;
  logic            core_w_s;
  logic            core_z_s;
  logic            core_rise_s;

  function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base, input int off);
    int s;
    s = int'(32'(base)) + off;
    return CH_W'((s >= N_CH) ? (s - N_CH) : s);
  endfunction

  // Round-robin search; scanning farthest-first lets the nearest eligible win.
  always_comb begin
    elig_s    = reset ? {N_CH{1'b0}} : (bus.req & ~bus.clr);
    gnt_any_s = 1'b0;
    gnt_idx_s = {CH_W{1'b0}};
    cand_s    = {CH_W{1'b0}};
    hit_s     = 1'b0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      cand_s    = wrap_add(ptr_r, k);
      hit_s     = elig_s[cand_s];
      gnt_idx_s = hit_s ? cand_s : gnt_idx_s;
      gnt_any_s = gnt_any_s | hit_s;
    end
    gnt_s            = {N_CH{1'b0}};
    gnt_s[gnt_idx_s] = gnt_any_s;
    ptr_next_s       = wrap_add(gnt_idx_s, 1);
  end

  // Steer the granted channel's state and sample into the shared engine.
  always_comb begin
    core_in_s = state_r[gnt_idx_s];
    core_w_s  = bus.w[gnt_idx_s];
  end

  run_detector_core #(
    .RUN_LEN (RUN_LEN)
  ) u_core (
    .state_in  (core_in_s),
    .w         (core_w_s),
    .state_out (core_out_s),
    .z_next    (core_z_s),
    .rise      (core_rise_s)
  );

  // Per-channel run state, detect flags, match pulse and rr pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        state_r[i] <= CHAN_STATE_RST;
      end
      z_r           <= {N_CH{1'b0}};
      match_valid_r <= 1'b0;
      match_ch_r    <= {CH_W{1'b0}};
      ptr_r         <= {CH_W{1'b0}};
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (bus.clr[i]) begin
          state_r[i] <= CHAN_STATE_RST;
          z_r[i]     <= 1'b0;
        end else if (gnt_s[i]) begin
          state_r[i] <= core_out_s;
          z_r[i]     <= core_z_s;
        end
      end
      match_valid_r <= gnt_any_s & core_rise_s;
      match_ch_r    <= (gnt_any_s & core_rise_s) ? gnt_idx_s : {CH_W{1'b0}};
      if (gnt_any_s) begin
        ptr_r <= ptr_next_s;
      end
    end
  end

  assign bus.gnt         = gnt_s;
  assign bus.z           = z_r;
  assign bus.match_valid = match_valid_r;
  assign bus.match_ch    = match_ch_r;

`ifdef RUNDET_STATS_EN
  logic [STAT_W-1:0] stat_r [N_CH];

  // Match counters follow the registered pulse and stick at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        stat_r[i] <= {STAT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (bus.clr[i]) begin
          stat_r[i] <= {STAT_W{1'b0}};
        end else if (match_valid_r && (match_ch_r == CH_W'(i)) &&
                     (stat_r[i] != {STAT_W{1'b1}})) begin
          stat_r[i] <= stat_r[i] + {{(STAT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign stat_cnt = stat_r[stat_sel];
`else
  logic unused_stat_sel_s;

  assign unused_stat_sel_s = ^stat_sel;
  assign stat_cnt          = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_run_detector_arbiter.sv
// Directed bench for run_detector_arbiter (N_CH=4, RUN_LEN=4): a vector table
// for arbitration/detection plus hand sequences for the match statistics.
module tb_run_detector_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] stat_sel;
  logic [7:0] stat_cnt;

  always #5 clk = ~clk;

  run_detector_arbiter_if #(.N_CH(4)) bus ();

  run_detector_arbiter #(
    .N_CH    (4),
    .RUN_LEN (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .stat_sel (stat_sel),
    .stat_cnt (stat_cnt)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] req;
    logic [3:0] w;
    logic [3:0] clr;
    logic [3:0] gnt;
    logic [3:0] z;
    logic       mv;
    logic [1:0] mch;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void add(input string n, input logic r, input logic [3:0] rq,
                              input logic [3:0] wv, input logic [3:0] cl, input logic [3:0] g,
                              input logic [3:0] zz, input logic mv, input logic [1:0] mch);
    vec_t v;
    v.name = n; v.rst = r; v.req = rq; v.w = wv; v.clr = cl;
    v.gnt = g; v.z = zz; v.mv = mv; v.mch = mch;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    reset   = v.rst;
    bus.req = v.req;
    bus.w   = v.w;
    bus.clr = v.clr;
    #1;
    chk({v.name, ".gnt"}, 32'(bus.gnt), 32'(v.gnt));
    @(posedge clk);
    #1;
    chk({v.name, ".z"}, 32'(bus.z), 32'(v.z));
    chk({v.name, ".mv"}, 32'(bus.match_valid), 32'(v.mv));
    chk({v.name, ".mch"}, 32'(bus.match_ch), 32'(v.mch));
  endtask

  task automatic send_bit(input int ch, input logic b);
    logic [3:0] one_hot;
    one_hot = 4'b0001 << ch;
    @(negedge clk);
    reset   = 1'b0;
    bus.clr = 4'b0000;
    bus.req = one_hot;
    bus.w   = b ? one_hot : 4'b0000;
    #1;
    chk("stat_seq.gnt", 32'(bus.gnt), 32'(one_hot));
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset   = 1'b0;
      bus.req = 4'b0000;
      bus.w   = 4'b0000;
      bus.clr = 4'b0000;
    end
  endtask

  initial begin
    logic       s2_bits [7];
    logic [3:0] g;
    logic [3:0] zz;
    logic [7:0] exp_three;
    logic [7:0] exp_sat;

    reset    = 1'b1;
    bus.req  = 4'b0000;
    bus.w    = 4'b0000;
    bus.clr  = 4'b0000;
    stat_sel = 2'd0;

    add("rst", 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);

    // ch0 run of zeros: rises on the 4th grant, saturates on the 5th
    add("s1_b1", 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0, 2'd0);
    add("s1_b2", 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0, 2'd0);
    add("s1_b3", 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0, 2'd0);
    add("s1_b4", 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 1'b1, 2'd0);
    add("s1_b5", 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 1'b0, 2'd0);
    add("s1_idle", 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0);

    // ch1 stream 1,1,1,0,0,0,0: only the last sample completes a run
    s2_bits = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 7; k++) begin
      add($sformatf("s2_b%0d", k + 1), 1'b0, 4'b0010, s2_bits[k] ? 4'b0010 : 4'b0000, 4'b0000,
          4'b0010, (k == 6) ? 4'b0011 : 4'b0001, (k == 6), (k == 6) ? 2'd1 : 2'd0);
    end
    add("s2_idle", 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 1'b0, 2'd0);

    // all channels requesting after reset: strict rotation, rises in order 0..3
    add("s3_rst", 1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
    for (int k = 0; k < 16; k++) begin
      g  = 4'b0001 << (k % 4);
      zz = (k < 12) ? 4'b0000 : (4'b1111 >> (15 - k));
      add($sformatf("s3_r%0d", k), 1'b0, 4'b1111, 4'b1111, 4'b0000, g, zz,
          (k >= 12), (k >= 12) ? 2'(k - 12) : 2'd0);
    end

    // saturation, clr masking, pointer hold, and rebuilding a cleared run
    add("s4_sat", 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b1111, 1'b0, 2'd0);
    add("s4_clr", 1'b0, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b1011, 1'b0, 2'd0);
    add("s4_ptr", 1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0010, 4'b1011, 1'b0, 2'd0);
    add("s4_c2b1", 1'b0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b1011, 1'b0, 2'd0);
    add("s4_c2b2", 1'b0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b1011, 1'b0, 2'd0);
    add("s4_c2b3", 1'b0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b1011, 1'b0, 2'd0);
    add("s4_c2b4", 1'b0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b1111, 1'b1, 2'd2);
    add("s4_clr0", 1'b0, 4'b1111, 4'b1111, 4'b0001, 4'b1000, 4'b1110, 1'b0, 2'd0);
    add("s4_c0b1", 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b1110, 1'b0, 2'd0);

    // reset while ch0 is one sample from a match
    add("s5_c0b2", 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b1110, 1'b0, 2'd0);
    add("s5_c0b3", 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b1110, 1'b0, 2'd0);
    add("s5_rst", 1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
    add("s5_g0", 1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 1'b0, 2'd0);
    add("s5_g1", 1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0010, 4'b0000, 1'b0, 2'd0);

    foreach (vecs[i]) begin
      apply(vecs[i]);
    end

`ifdef RUNDET_STATS_EN
    exp_three = 8'd3;
    exp_sat   = 8'd255;
`else
    exp_three = 8'd0;
    exp_sat   = 8'd0;
`endif

    // statistics: three runs on ch3, then enough runs to saturate
    @(negedge clk);
    reset   = 1'b1;
    bus.req = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int b = 0; b < 4; b++) begin
        send_bit(3, (r == 1));
      end
    end
    idle(2);
    stat_sel = 2'd3;
    #1;
    chk("stat_ch3_three", 32'(stat_cnt), 32'(exp_three));
    stat_sel = 2'd0;
    #1;
    chk("stat_ch0_zero", 32'(stat_cnt), 32'd0);

    for (int r = 0; r < 260; r++) begin
      for (int b = 0; b < 4; b++) begin
        send_bit(3, (r % 2 == 0));
      end
    end
    idle(2);
    stat_sel = 2'd3;
    #1;
    chk("stat_ch3_sat", 32'(stat_cnt), 32'(exp_sat));

    @(negedge clk);
    bus.clr = 4'b1000;
    @(negedge clk);
    bus.clr = 4'b0000;
    #1;
    chk("stat_ch3_clr", 32'(stat_cnt), 32'd0);
    chk("clr_z3", 32'(bus.z), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/run_detector_arbiter.md
Name: run_detector_arbiter

Overview:
Shares one run-length sequence-detector engine among N_CH serial bit channels. Each channel holds a run state (last bit plus a saturating run count) in a per-channel register, and a round-robin arbiter grants one channel per cycle. The granted channel's sample is passed through the shared next-state logic. Detection rule: z asserts after RUN_LEN consecutive equal bits (0s or 1s) and stays high while the run continues. The block sits between the switch/serial sources and the LED or status logic.

Parameters:
N_CH, 4, number of requesting channels (2..16)
RUN_LEN, 4, consecutive equal bits needed to assert z (2..15)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
req  in  N_CH  per-channel sample request; hold until gnt
w  in  N_CH  per-channel sample bit; valid while req
clr  in  N_CH  per-channel synchronous state clear
gnt  out  N_CH  one-hot grant (combinational); sample consumed at this clock edge
z  out  N_CH  registered per-channel detect flag
match_valid  out  1  registered one-cycle pulse when a channel's z rises
match_ch  out  $clog2(N_CH)  channel index for match_valid; 0 when idle
stat_sel  in  $clog2(N_CH)  channel select for statistics readout
stat_cnt  out  8  selected channel's match count (see Optional Feature)

Behaviour:
- Reset (sync, highest priority): all channel states cnt=0, last=0; z=0; match_valid=0; match_ch=0; rr pointer=0; stat counters=0.
- Eligibility: channel i is eligible when req[i] & ~clr[i].
- Arbitration: search starts at rr pointer and wraps modulo N_CH. The first eligible channel gets gnt. At most one gnt bit is high. If no channel is eligible, gnt=0.
- Pointer update: after a grant to channel i, pointer becomes (i+1) mod N_CH. With no grant, the pointer holds.
- Shared next-state, applied only to the granted channel at the clock edge:
  - cnt==0: cnt=1, last=w.
  - w==last: cnt=min(cnt+1, RUN_LEN).
  - w!=last: cnt=1, last=w.
  - Non-granted channels hold their state.
- z[i] = (cnt_i == RUN_LEN), registered. Latency is 1 cycle from the granted sample to z.
- match_valid=1 and match_ch=i in the cycle after a granted sample moves cnt_i from RUN_LEN-1 to RUN_LEN. A saturated run (RUN_LEN to RUN_LEN) does not pulse.
- clr[i]: at the next edge, cnt_i=0, last_i=0, z[i]=0. Channel i is masked from arbitration in that cycle, so its sample is not consumed. clr on one channel does not affect the others or the pointer.
- Requester protocol: the requester keeps req/w stable until it sees gnt. It may present its next bit in the cycle after gnt. Dropping req without gnt is legal; no sample is taken.
- Reset mid-operation clears all state regardless of pending req; no gnt is issued while reset=1.
- Count width is CNT_W = $clog2(RUN_LEN+1) and saturates; it never wraps.

Optional Feature:
Macro RUNDET_STATS_EN.
- Defined: each channel has an 8-bit match counter that increments on every match_valid for that channel and saturates at 255. Counters are cleared by reset and by clr[i]. stat_cnt = counter[stat_sel] (combinational mux).
- Undefined: no counters exist; stat_cnt is tied to 0 and stat_sel is unused. Ports are present in both builds.

Decomposition:
- Package run_detector_pkg holds: CNT_W computation; the chan_state_t struct {last, cnt}; a reset constant for chan_state_t; the statistics counter width constant (8).
- Sub-module run_detector_core: purely combinational next-state function (state_in, w) -> (state_out, z_next, rise). Instantiated once, with its input muxed by gnt.
- Arbiter and state registers stay in the top module.

Test Plan:
All scenarios use N_CH=4, RUN_LEN=4.
1. Reset; ch0 req with w=0 for 4 grants -> z[0]=1 one cycle after the 4th grant; match_valid=1 with match_ch=0 for exactly 1 cycle. A 5th 0 keeps z[0]=1 with no new pulse.
2. ch1 stream 1,1,1,0,0,0,0 -> z[1]=0 through the 6th sample, 1 after the 7th; exactly one match pulse.
3. req=4'b1111 held -> gnt sequence 0001, 0010, 0100, 1000, 0001. Each channel receives every 4th slot.
4. req=4'b0100 with clr[2]=1 in the same cycle -> gnt=0; next cycle z[2]=0 and ch2 cnt=0; pointer unchanged.
5. z[1]=1 and ch3 mid-run, then reset pulse -> next cycle z=0, match_valid=0, and the first grant with req=4'b1111 goes to ch0.
6. RUNDET_STATS_EN defined: ch3 runs 0000, 1111, 0000 -> stat_sel=3 gives stat_cnt=3; after 260 forced matches, stat_cnt=255. Undefined build: stat_cnt=0 always.
